// File: rtl/mem2_stage.sv
// MEM2 pipeline stage: registers the MEM1 bundle, waits out D-cache load misses,
// drains responses owed to flushed loads, and counts miss-stall cycles.
module mem2_stage #(
  parameter int DW   = 32,
  parameter int CNTW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            MEM2_Flush,
  input  logic            MEM2_Wr,
  input  logic            MEM_Valid,
  input  logic            MEM_IsLoad,
  input  logic [DW-1:0]   MEM_ALUOut,
  input  logic [DW-1:0]   MEM_PC,
  input  logic [DW-1:0]   MEM_Instr,
  input  logic [DW-1:0]   MEM_OutB,
  input  logic [DW-1:0]   MEM_Result,
  input  logic [2:0]      MEM_LoadType,
  input  logic [1:0]      MEM_WbSel,
  input  logic [4:0]      MEM_Dst,
  input  logic [2:0]      MEM_RegsWrType,
  input  logic            dcache_rvalid,
  input  logic [DW-1:0]   dcache_rdata,
  output logic [DW-1:0]   MEM2_ALUOut,
  output logic [DW-1:0]   MEM2_PC,
  output logic [DW-1:0]   MEM2_Instr,
  output logic [DW-1:0]   MEM2_OutB,
  output logic [DW-1:0]   MEM2_Result,
  output logic [2:0]      MEM2_LoadType,
  output logic [1:0]      MEM2_WbSel,
  output logic [4:0]      MEM2_Dst,
  output logic [2:0]      MEM2_RegsWrType,
  output logic [DW-1:0]   MEM2_DMOut,
  output logic            MEM2_Stall,
  output logic [CNTW-1:0] MEM2_MissCycles
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [DW-1:0]   alu_q, pc_q, instr_q, outb_q, result_q, dbuf_q;
  logic [2:0]      ldtype_q, rwt_q;
  logic [1:0]      wbsel_q;
  logic [4:0]      dst_q;
  logic [CNTW-1:0] miss_q;

  logic capture_s, new_load_s, buf_we_s, stall_s;

  // Capture gating, buffer write enable and next-state selection
  always_comb begin
    capture_s  = 1'b0;
    new_load_s = 1'b0;
    buf_we_s   = 1'b0;
    stall_s    = 1'b0;
    state_d    = state_q;
    // A pending miss and an owed drain response both freeze the stage register
    capture_s  = !MEM2_Flush && MEM2_Wr && (state_q != S_DRAIN) &&
                 !((state_q == S_WAIT) && !dcache_rvalid);
    new_load_s = capture_s && MEM_Valid && MEM_IsLoad;
    stall_s    = ((state_q == S_WAIT) || (state_q == S_DRAIN)) && !dcache_rvalid;
    case (state_q)
      S_IDLE: begin
        if (new_load_s) state_d = S_WAIT;
        else            state_d = S_IDLE;
      end
      S_WAIT: begin
        if (!dcache_rvalid) begin
          if (MEM2_Flush) state_d = S_DRAIN;
          else            state_d = S_WAIT;
        end else begin
          buf_we_s = !MEM2_Flush;
          if (new_load_s) state_d = S_WAIT;
          else            state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (dcache_rvalid) state_d = S_IDLE;
        else               state_d = S_DRAIN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, payload, data buffer and stall counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      alu_q    <= '0;
      pc_q     <= '0;
      instr_q  <= '0;
      outb_q   <= '0;
      result_q <= '0;
      dbuf_q   <= '0;
      ldtype_q <= 3'b000;
      rwt_q    <= 3'b000;
      wbsel_q  <= 2'b00;
      dst_q    <= 5'd0;
      miss_q   <= '0;
    end else begin
      state_q <= state_d;
      if (stall_s) miss_q <= miss_q + {{(CNTW-1){1'b0}}, 1'b1};
      if (buf_we_s) dbuf_q <= dcache_rdata;
      if (MEM2_Flush) begin
        ldtype_q <= 3'b000;
        rwt_q    <= 3'b000;
        wbsel_q  <= 2'b00;
        dst_q    <= 5'd0;
      end else if (capture_s) begin
        alu_q    <= MEM_ALUOut;
        pc_q     <= MEM_PC;
        instr_q  <= MEM_Instr;
        outb_q   <= MEM_OutB;
        result_q <= MEM_Result;
        ldtype_q <= MEM_LoadType;
        rwt_q    <= MEM_RegsWrType & {3{MEM_Valid}};
        wbsel_q  <= MEM_WbSel;
        dst_q    <= MEM_Dst;
      end
    end
  end

  assign MEM2_ALUOut     = alu_q;
  assign MEM2_PC         = pc_q;
  assign MEM2_Instr      = instr_q;
  assign MEM2_OutB       = outb_q;
  assign MEM2_Result     = result_q;
  assign MEM2_LoadType   = ldtype_q;
  assign MEM2_WbSel      = wbsel_q;
  assign MEM2_Dst        = dst_q;
  assign MEM2_RegsWrType = rwt_q;
  assign MEM2_MissCycles = miss_q;
  assign MEM2_Stall      = stall_s;
  // Hit data bypasses the buffer so WB sees it in the response cycle
  assign MEM2_DMOut      = ((state_q == S_WAIT) && dcache_rvalid) ? dcache_rdata : dbuf_q;

endmodule

// File: tb/tb_mem2_stage.sv
// Directed self-checking bench for mem2_stage: ALU op, load hit, miss, flush/drain,
// back-to-back loads and reset during a pending miss.
module tb_mem2_stage;
  logic        clk = 1'b0;
  logic        rst, flush, wr, valid, isload, rvalid;
  logic [31:0] alu, pc, instr, outb, result, rdata;
  logic [2:0]  ldtype, rwt;
  logic [1:0]  wbsel;
  logic [4:0]  dst;
  logic [31:0] o_alu, o_pc, o_instr, o_outb, o_result, o_dm, o_miss;
  logic [2:0]  o_ldtype, o_rwt;
  logic [1:0]  o_wbsel;
  logic [4:0]  o_dst;
  logic        o_stall;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem2_stage #(.DW(32), .CNTW(32)) dut (
    .clk(clk), .rst(rst), .MEM2_Flush(flush), .MEM2_Wr(wr),
    .MEM_Valid(valid), .MEM_IsLoad(isload),
    .MEM_ALUOut(alu), .MEM_PC(pc), .MEM_Instr(instr), .MEM_OutB(outb), .MEM_Result(result),
    .MEM_LoadType(ldtype), .MEM_WbSel(wbsel), .MEM_Dst(dst), .MEM_RegsWrType(rwt),
    .dcache_rvalid(rvalid), .dcache_rdata(rdata),
    .MEM2_ALUOut(o_alu), .MEM2_PC(o_pc), .MEM2_Instr(o_instr), .MEM2_OutB(o_outb),
    .MEM2_Result(o_result), .MEM2_LoadType(o_ldtype), .MEM2_WbSel(o_wbsel),
    .MEM2_Dst(o_dst), .MEM2_RegsWrType(o_rwt), .MEM2_DMOut(o_dm),
    .MEM2_Stall(o_stall), .MEM2_MissCycles(o_miss)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic ld, input logic [31:0] p, input logic [4:0] d,
                        input logic [2:0] rw, input logic [1:0] wb, input logic [2:0] lt);
    valid = v; isload = ld; pc = p; dst = d; rwt = rw; wbsel = wb; ldtype = lt;
    alu = p ^ 32'h0000_FFFF; instr = p + 32'd4; outb = p + 32'd8; result = p + 32'd12;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; wr = 1'b1; rvalid = 1'b0; rdata = 32'd0;
    set_in(1'b0, 1'b0, 32'd0, 5'd0, 3'b000, 2'b00, 3'b000);
    tick(); tick();
    rst = 1'b0;
    chk("rst_pc", o_pc, 32'd0);
    chk("rst_dm", o_dm, 32'd0);
    chk("rst_stall", {31'd0, o_stall}, 32'd0);
    chk("rst_miss", o_miss, 32'd0);

    // ALU op
    set_in(1'b1, 1'b0, 32'hBFC0_0000, 5'd5, 3'b100, 2'b01, 3'b000);
    tick();
    chk("alu_pc", o_pc, 32'hBFC0_0000);
    chk("alu_dst", {27'd0, o_dst}, 32'd5);
    chk("alu_rwt", {29'd0, o_rwt}, 32'd4);
    chk("alu_aluout", o_alu, 32'hBFC0_FFFF);
    chk("alu_stall", {31'd0, o_stall}, 32'd0);
    set_in(1'b0, 1'b0, 32'h0000_0050, 5'd6, 3'b100, 2'b01, 3'b000);
    tick();
    chk("bubble_rwt_masked", {29'd0, o_rwt}, 32'd0);
    chk("bubble_stall", {31'd0, o_stall}, 32'd0);

    // Load hit
    set_in(1'b1, 1'b1, 32'h0000_0100, 5'd7, 3'b100, 2'b11, 3'b010);
    tick();
    set_in(1'b0, 1'b0, 32'h0000_0104, 5'd0, 3'b000, 2'b00, 3'b000);
    rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
    #1;
    chk("hit_stall", {31'd0, o_stall}, 32'd0);
    chk("hit_dm_bypass", o_dm, 32'hDEAD_BEEF);
    chk("hit_pc", o_pc, 32'h0000_0100);
    chk("hit_wbsel", {30'd0, o_wbsel}, 32'd3);
    chk("hit_ldtype", {29'd0, o_ldtype}, 32'd2);
    tick();
    rvalid = 1'b0; rdata = 32'd0;
    #1;
    chk("hit_dm_after", o_dm, 32'hDEAD_BEEF);
    chk("hit_stall_after", {31'd0, o_stall}, 32'd0);
    chk("hit_miss_cnt", o_miss, 32'd0);

    // Load miss, response 4 cycles after capture
    set_in(1'b1, 1'b1, 32'h0000_0200, 5'd9, 3'b100, 2'b11, 3'b000);
    tick();
    set_in(1'b1, 1'b0, 32'h0000_0300, 5'd10, 3'b100, 2'b01, 3'b000);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("miss_stall", {31'd0, o_stall}, 32'd1);
      chk("miss_pc_held", o_pc, 32'h0000_0200);
      chk("miss_dst_held", {27'd0, o_dst}, 32'd9);
      tick();
    end
    rvalid = 1'b1; rdata = 32'hCAFE_F00D;
    #1;
    chk("miss_resp_stall", {31'd0, o_stall}, 32'd0);
    chk("miss_resp_dm", o_dm, 32'hCAFE_F00D);
    chk("miss_cnt", o_miss, 32'd3);
    chk("miss_resp_pc", o_pc, 32'h0000_0200);
    tick();
    rvalid = 1'b0; rdata = 32'd0;
    set_in(1'b0, 1'b0, 32'h0000_0304, 5'd0, 3'b000, 2'b00, 3'b000);
    #1;
    chk("miss_next_pc", o_pc, 32'h0000_0300);
    chk("miss_dm_buf", o_dm, 32'hCAFE_F00D);
    chk("miss_next_stall", {31'd0, o_stall}, 32'd0);
    chk("miss_cnt_hold", o_miss, 32'd3);

    // Flush one cycle after capture of a load
    set_in(1'b1, 1'b1, 32'h0000_0400, 5'd3, 3'b100, 2'b11, 3'b001);
    tick();
    flush = 1'b1;
    #1;
    chk("fl_wait_stall", {31'd0, o_stall}, 32'd1);
    tick();
    flush = 1'b0;
    set_in(1'b1, 1'b1, 32'h0000_0500, 5'd11, 3'b100, 2'b11, 3'b000);
    #1;
    chk("fl_rwt", {29'd0, o_rwt}, 32'd0);
    chk("fl_dst", {27'd0, o_dst}, 32'd0);
    chk("fl_wbsel", {30'd0, o_wbsel}, 32'd0);
    chk("fl_drain_stall1", {31'd0, o_stall}, 32'd1);
    tick();
    chk("fl_drain_stall2", {31'd0, o_stall}, 32'd1);
    chk("fl_drain_rwt", {29'd0, o_rwt}, 32'd0);
    tick();
    rvalid = 1'b1; rdata = 32'h1234_5678;
    #1;
    chk("fl_resp_stall", {31'd0, o_stall}, 32'd0);
    chk("fl_resp_dm", o_dm, 32'hCAFE_F00D);
    chk("fl_cnt", o_miss, 32'd6);
    tick();
    rvalid = 1'b0; rdata = 32'd0;
    set_in(1'b0, 1'b0, 32'h0000_0504, 5'd0, 3'b000, 2'b00, 3'b000);
    #1;
    chk("fl_after_dm", o_dm, 32'hCAFE_F00D);
    chk("fl_after_stall", {31'd0, o_stall}, 32'd0);
    chk("fl_after_rwt", {29'd0, o_rwt}, 32'd0);
    chk("fl_after_cnt", o_miss, 32'd6);

    // Back-to-back: response coincides with the next load capture
    set_in(1'b1, 1'b1, 32'h0000_0600, 5'd12, 3'b100, 2'b11, 3'b000);
    tick();
    set_in(1'b1, 1'b1, 32'h0000_0700, 5'd13, 3'b100, 2'b11, 3'b000);
    rvalid = 1'b1; rdata = 32'hA5A5_A5A5;
    #1;
    chk("b2b_dm", o_dm, 32'hA5A5_A5A5);
    chk("b2b_stall0", {31'd0, o_stall}, 32'd0);
    tick();
    rvalid = 1'b0; rdata = 32'd0;
    set_in(1'b0, 1'b0, 32'h0000_0800, 5'd0, 3'b000, 2'b00, 3'b000);
    #1;
    chk("b2b_stall1", {31'd0, o_stall}, 32'd1);
    chk("b2b_pc", o_pc, 32'h0000_0700);
    chk("b2b_dm_buf", o_dm, 32'hA5A5_A5A5);
    tick();
    chk("b2b_cnt", o_miss, 32'd7);

    // Reset for two cycles while still in WAIT
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst2_pc", o_pc, 32'd0);
    chk("rst2_rwt", {29'd0, o_rwt}, 32'd0);
    chk("rst2_dm", o_dm, 32'd0);
    chk("rst2_cnt", o_miss, 32'd0);
    chk("rst2_stall", {31'd0, o_stall}, 32'd0);

    // Stray response in IDLE must be ignored
    rvalid = 1'b1; rdata = 32'hFFFF_0000;
    tick();
    rvalid = 1'b0; rdata = 32'd0;
    #1;
    chk("idle_rv_dm", o_dm, 32'd0);
    chk("idle_rv_stall", {31'd0, o_stall}, 32'd0);
    tick();
    chk("idle_rv_cnt", o_miss, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
